// File: rtl/fc_argmax_stage.sv
// fc_argmax_stage: captures a packed signed vector on a rising in_done, scans it serially for
// the maximum (lowest index wins ties) and offers class/value on a valid/ready port.
module fc_argmax_stage #(
  parameter int N = 8,
  parameter int W = 8,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_done,
  input  logic [W*N-1:0]   in_vector_flat,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_class,
  output logic [W-1:0]     out_max,
  output logic             busy,
  output logic             overrun
);
  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);
  state_t state_q, state_d;
  logic done_q, done_d;
  logic [W*N-1:0] vec_q, vec_d;
  logic [IDX_W-1:0] idx_q, idx_d, best_idx_q, best_idx_d, out_class_q, out_class_d;
  logic [W-1:0] best_q, best_d, out_max_q, out_max_d;
  logic out_valid_q, out_valid_d, busy_q, busy_d, overrun_q, overrun_d;
  logic [W-1:0] elem [N];
  logic rise, take;
  logic [W-1:0] cur, nbest;
  logic [IDX_W-1:0] nidx;
  for (genvar g = 0; g < N; g++) begin : g_elem
    assign elem[g] = vec_q[g*W +: W];
  end
  assign rise  = in_done && !done_q;
  assign cur   = elem[idx_q];
  assign take  = $signed(cur) > $signed(best_q);
  assign nbest = take ? cur : best_q;
  assign nidx  = take ? idx_q : best_idx_q;
  always_comb begin
    state_d     = state_q;
    done_d      = in_done;
    vec_d       = vec_q;
    idx_d       = idx_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    out_valid_d = out_valid_q;
    out_class_d = out_class_q;
    out_max_d   = out_max_q;
    overrun_d   = overrun_q || (rise && state_q != IDLE);
    case (state_q)
      IDLE: if (rise) begin
        vec_d       = in_vector_flat;
        best_d      = in_vector_flat[W-1:0];
        best_idx_d  = '0;
        idx_d       = IDX_W'(1);
        state_d     = (N == 1) ? HOLD : SCAN;
        out_valid_d = (N == 1) ? 1'b1 : out_valid_q;
        out_class_d = (N == 1) ? '0 : out_class_q;
        out_max_d   = (N == 1) ? in_vector_flat[W-1:0] : out_max_q;
      end
      SCAN: begin
        best_d     = nbest;
        best_idx_d = nidx;
        if (idx_q == LAST) begin
          out_class_d = nidx;
          out_max_d   = nbest;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      HOLD: if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      done_q      <= 1'b0;
      vec_q       <= '0;
      idx_q       <= '0;
      best_q      <= '0;
      best_idx_q  <= '0;
      out_valid_q <= 1'b0;
      out_class_q <= '0;
      out_max_q   <= '0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      vec_q       <= vec_d;
      idx_q       <= idx_d;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      out_valid_q <= out_valid_d;
      out_class_q <= out_class_d;
      out_max_q   <= out_max_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_class = out_class_q;
  assign out_max   = out_max_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;
endmodule

// File: doc/fc_argmax_stage.md
# fc_argmax_stage

Downstream classifier stage for the fully-connected layer. Captures the layer's packed ReLU output vector when the layer's level-high `done` rises, serially scans the OUT_SIZE activations (one compare per clock) for the maximum, and presents the winning class index and value on a valid/ready output port. Sits between the final FC layer and the result/readout logic.

## Interface
- `N`, 8: number of input activations (classes), ≥1.
- `W`, 8: activation width in bits, two's complement.
- `IDX_W`, `(N>1) ? $clog2(N) : 1`: class index width.

- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `in_done`  in  1  upstream completion level (connect to FC layer `done`), sampled for rising edge
- `in_vector_flat`  in  W*N  packed activations, element i at bits [i*W +: W], signed
- `out_ready`  in  1  consumer ready
- `out_valid`  out  1  result valid
- `out_class`  out  IDX_W  index of maximum element
- `out_max`  out  W  value of maximum element, signed
- `busy`  out  1  high whenever state ≠ IDLE
- `overrun`  out  1  sticky: rising edge of `in_done` arrived while not IDLE

## Operation
- Internal registers:
  - `done_q` (previous `in_done`).
  - `vec_q` (captured vector, W*N).
  - `idx` (scan pointer, IDX_W).
  - `best`, `best_idx`.
  - `state` ∈ {IDLE, SCAN, HOLD}.
- Rising edge = `in_done && !done_q`. `done_q <= in_done` every cycle, in all states.
- IDLE, rising edge:
  - `vec_q <= in_vector_flat`, `best <= elem0`, `best_idx <= 0`, `idx <= 1`.
  - N≥2: go to SCAN.
  - N=1: go straight to HOLD with `out_valid <= 1`, `out_class <= 0`, `out_max <= elem0`.
- SCAN, each cycle:
  - If `$signed(vec_q[idx]) > $signed(best)` (strict), `best`/`best_idx` take that element and index.
  - Ties keep the lower index.
  - When `idx == N-1`, load the final compare result into `out_class`/`out_max`, set `out_valid <= 1`, go to HOLD. Otherwise `idx <= idx+1`.
- HOLD:
  - `out_valid`, `out_class`, `out_max` stay stable until a clock edge with `out_valid && out_ready`.
  - At that edge: `out_valid <= 0`, go to IDLE.
  - `out_class`/`out_max` keep their last value after the handshake.
- Rising edge of `in_done` in SCAN or HOLD: ignored (vector not recaptured), `overrun <= 1`. Only reset clears `overrun`.
- A rising edge in the same cycle as the HOLD handshake is also an overrun. It is not captured; state returns to IDLE.
- Negative inputs are legal (full signed compare), even though upstream ReLU only produces 0..2^(W-1)-1.

## Timing
- Reset (synchronous, dominates all other inputs):
  - `state=IDLE`, `done_q=0`.
  - `out_valid=0`, `out_class=0`, `out_max=0`, `busy=0`, `overrun=0`.
- Because `done_q` resets to 0, an `in_done` still high on the first post-reset cycle is treated as a rising edge. Upstream shares the same reset, so its `done` is low then.
- Capture at clock edge T (first edge sampling `in_done=1` with `done_q=0`).
  - `out_valid` is high after edge T+N-1 (N≥2), or after edge T (N=1).
  - Throughput: one vector per N cycles plus the handshake cycle.
- `busy` is registered: high from edge T through the handshake edge.
- Reset asserted mid-SCAN or in HOLD aborts the operation. Nothing is output, and the next rising edge is processed normally.
- `out_ready` is ignored when `out_valid=0`. No combinational path from any input to any output.

## Test plan
- N=8, W=8, vector {3,17,5,99,0,42,99,1}, `in_done` 0→1, `out_ready=1` → `out_valid` rises 7 cycles after capture, `out_class=3`, `out_max=99` (tie resolved to lower index); `busy` falls after the handshake.
- All-zero vector → `out_class=0`, `out_max=0`. Vector with max in last slot {1,2,3,4,5,6,7,127} → `out_class=7`, `out_max=127`.
- Backpressure: `out_ready=0` for 10 cycles after `out_valid` → outputs stable; `out_ready=1` → exactly one handshake; `out_valid=0` the next cycle; `in_done` held high afterward triggers no second capture.
- Overrun: second `in_done` rising edge (after a low pulse) during SCAN with a different vector → `overrun=1`, result still reflects the first vector; `overrun` stays 1 until reset.
- Reset asserted on the 3rd SCAN cycle → next cycle all outputs 0, state IDLE; a new rising edge with {-5,-2,-9,-2,-100,-3,-7,-8} → `out_class=1`, `out_max=-2`.
- N=1 instance: capture value 42 → `out_valid` after edge T, `out_class=0`, `out_max=42`.
